// File: rtl/maze_rom_arbiter.sv
// Two-port arbiter in front of the single synchronous maze ROM: movement wall checks and
// display cell scans share one read per cycle, with tags routing each wall bit back home.
module maze_rom_arbiter #(
    parameter int ADDR_WIDTH  = 11,
    parameter int ROM_LATENCY = 1,
    parameter int BURST_MAX   = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  move_req,
    input  logic [ADDR_WIDTH-1:0] move_addr,
    output logic                  move_ack,
    output logic                  move_rvalid,
    output logic                  move_rdata,
    input  logic                  disp_req,
    input  logic [ADDR_WIDTH-1:0] disp_addr,
    input  logic                  disp_burst,
    output logic                  disp_ack,
    output logic                  disp_rvalid,
    output logic                  disp_rdata,
    output logic [ADDR_WIDTH-1:0] rom_address,
    input  logic                  rom_data
);

    localparam int CNT_W = $clog2(BURST_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);

    typedef enum logic {
        OWN_MOVE = 1'b0,
        OWN_DISP = 1'b1
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
    } tag_t;

    owner_e                last_owner_q, last_owner_d;
    logic [CNT_W-1:0]      burst_cnt_q, burst_cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    tag_t                  tag_q [ROM_LATENCY];
    tag_t                  tag_d [ROM_LATENCY];

    logic grant_move;
    logic grant_disp;
    logic burst_hold;
    tag_t tag_out;

    // Display keeps the ROM during a row scan until it has used up its burst allowance.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        grant_move = 1'b0;
        grant_disp = 1'b0;
        burst_hold = disp_burst && (last_owner_q == OWN_DISP) && (burst_cnt_q < CNT_MAX);
        if (move_req && disp_req) begin
            if (burst_hold || (last_owner_q == OWN_MOVE)) begin
                grant_disp = 1'b1;
            end else begin
                grant_move = 1'b1;
            end
        end else begin
            grant_move = move_req;
            grant_disp = disp_req;
        end
    end

    always_comb begin
        last_owner_d = last_owner_q;
        burst_cnt_d  = burst_cnt_q;
        addr_d       = addr_q;

        if (grant_move) begin
            last_owner_d = OWN_MOVE;
            addr_d       = move_addr;
        end else if (grant_disp) begin
            last_owner_d = OWN_DISP;
            addr_d       = disp_addr;
        end

        if (!disp_burst || grant_move) begin
            burst_cnt_d = '0;
        end else if (grant_disp && move_req && (burst_cnt_q < CNT_MAX)) begin
            burst_cnt_d = burst_cnt_q + CNT_W'(1);
        end

        tag_d[0].valid = grant_move || grant_disp;
        tag_d[0].owner = grant_disp ? OWN_DISP : OWN_MOVE;
        for (int i = 1; i < ROM_LATENCY; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            last_owner_q <= OWN_DISP;
            burst_cnt_q  <= '0;
            addr_q       <= '0;
            // NOTE: the tag shift register is reset (unlike a data RAM) so in-flight reads are flushed.
            for (int i = 0; i < ROM_LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            last_owner_q <= last_owner_d;
            burst_cnt_q  <= burst_cnt_d;
            addr_q       <= addr_d;
            for (int i = 0; i < ROM_LATENCY; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    // Acks and address are combinational, so they are gated directly by the async reset.
    assign move_ack    = reset && grant_move;
    assign disp_ack    = reset && grant_disp;
    assign rom_address = reset ? addr_d : '0;

    assign tag_out     = tag_q[ROM_LATENCY-1];
    assign move_rvalid = tag_out.valid && (tag_out.owner == OWN_MOVE);
    assign disp_rvalid = tag_out.valid && (tag_out.owner == OWN_DISP);
    assign move_rdata  = move_rvalid && rom_data;
    assign disp_rdata  = disp_rvalid && rom_data;

endmodule

// File: doc/maze_rom_arbiter.md
Name: maze_rom_arbiter

Overview:
- Shares the single synchronous maze ROM (11-bit address, 1-bit wall data) between two requesters.
- Requester 1 is the player-movement wall-check logic; requester 2 is the display renderer scanning maze cells.
- Arbitrates per cycle and accepts at most one read per cycle, fully pipelined.
- Tags each read so the returned wall bit reaches the requester that issued it.

Parameters:
- ADDR_WIDTH, 11, maze ROM address width.
- ROM_LATENCY, 1, cycles from rom_address change to valid rom_data (legal range 1..4).
- BURST_MAX, 4, maximum consecutive display grants while a movement request is pending and disp_burst is high (legal range 1..15).

Ports:
- clock  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- move_req  in  1  movement read request; held high with move_addr stable until move_ack.
- move_addr  in  ADDR_WIDTH  movement read address.
- move_ack  out  1  combinational; the movement request is accepted this cycle.
- move_rvalid  out  1  movement read data valid.
- move_rdata  out  1  movement wall bit (1 = wall).
- disp_req  in  1  display read request; same hold rule as move_req.
- disp_addr  in  ADDR_WIDTH  display read address.
- disp_burst  in  1  display asks to keep the ROM for a row scan.
- disp_ack  out  1  combinational; the display request is accepted this cycle.
- disp_rvalid  out  1  display read data valid.
- disp_rdata  out  1  display wall bit.
- rom_address  out  ADDR_WIDTH  address to the maze ROM.
- rom_data  in  1  ROM output, valid ROM_LATENCY cycles after its address.

Behaviour:
- Reset (reset=0, asynchronous):
  - last_owner=DISP, burst_cnt=0, tag pipeline cleared.
  - rom_address is forced to 0 while in reset.
  - All ack, rvalid and rdata outputs are 0.
  - The first contention after reset goes to movement.
- Grant in cycle t:
  - Only one req high: that requester is granted.
  - Both high: round-robin, so the requester not in last_owner wins. Exception: burst rule below.
  - Neither high: no grant; rom_address holds its previous value; no tag is issued.
- Burst rule: if disp_burst=1, last_owner=DISP and burst_cnt<BURST_MAX, display wins contention.
- burst_cnt:
  - Increments on each display grant made while move_req=1 and disp_burst=1.
  - Clears on any movement grant, and on any cycle with disp_burst=0.
  - Saturates at BURST_MAX. On reaching it, the next contention goes to movement.
- Ack and address:
  - The granted requester's ack is high in cycle t; at most one ack is high per cycle.
  - rom_address is combinational from the granted address in cycle t.
  - rom_address is registered-hold when there is no grant.
- last_owner updates at the end of t on any grant.
- Tag pipeline:
  - A ROM_LATENCY-deep shift of {valid, owner} entries; one entry is issued per grant.
  - At cycle t+ROM_LATENCY, the owner's rvalid=1 and its rdata=rom_data.
  - The other requester's rvalid=0 and rdata=0.
  - rdata is 0 whenever rvalid=0.
- Throughput: one read per cycle. Back-to-back grants to the same or different requesters return in issue order, one per cycle.
- Requests are not queued. A requester not acked re-presents its request next cycle and must not change its address while waiting.
- Reset mid-operation flushes in-flight tags: no rvalid is produced for reads issued before reset, and outputs return to reset values immediately.
- req deasserted without ack: the request is dropped, no side effects.
- Tag pipeline sizing: sized for ROM_LATENCY; no overflow is possible because issue rate ≤ 1 per cycle.

Test Plan:
- Reset: hold reset=0 with random inputs → all acks/rvalids/rdata 0, rom_address 0; release, idle 5 cycles → outputs stay 0.
- Single read: move_req=1, move_addr=0x01B, ROM bit 1 at 0x01B → move_ack=1 and rom_address=0x01B in cycle t; move_rvalid=1 and move_rdata=1 in t+1; disp_rvalid=0 throughout.
- Contention: both req held high, disp_burst=0, 6 cycles after reset → grant order M,D,M,D,M,D; each rvalid follows its ack by exactly 1 cycle.
- Burst: BURST_MAX=4, last grant DISP, disp_burst=1, both req high → grants D,D,D,D,M,D… and burst_cnt clears after the M grant.
- Pipelined latency: ROM_LATENCY=2, display reads addr 0,1,2,3 on consecutive cycles, ROM pattern 1,0,1,1 → disp_rvalid high cycles t+2..t+5 with rdata 1,0,1,1 in order.
- Mid-op reset: grant move at cycle t, assert reset during t+0.5 → move_rvalid never asserts; after release, a fresh move read completes normally.
